// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit owning architectural HI/LO.
// A start in IDLE latches the operands and the opcode, then the unit runs
// MULT_CYCLES or DIV_CYCLES busy cycles and commits HI/LO on the last edge.
// Optional feature macro: MDU_DIV0_KEEP_EN. When it is defined, a divide by
// zero is never started, so HI/LO keep their old values. When it is undefined,
// a divide by zero runs normally and commits HI=dividend, LO=0xFFFFFFFF.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp_E,
  input  logic [31:0] V1_E,
  input  logic [31:0] V2_E,
  output logic        Busy,
  output logic        Stall_Req,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          busy_q, busy_d;

  // Result datapath; works only from the latched operands.
  logic [63:0] prod_s, prod_u;
  logic        is_sdiv, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;
  logic [31:0] res_hi, res_lo;

  // Signed divide goes through magnitudes so that 0x80000000 / -1 never overflows.
  always_comb begin
    prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u  = {32'd0, a_q} * {32'd0, b_q};
    is_sdiv = (op_q == OP_DIV);
    a_neg   = is_sdiv & a_q[31];
    b_neg   = is_sdiv & b_q[31];
    a_mag   = a_neg ? (32'd0 - a_q) : a_q;
    b_mag   = b_neg ? (32'd0 - b_q) : b_q;
    b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / b_safe;
    r_mag   = a_mag % b_safe;
    res_hi  = hi_q;
    res_lo  = lo_q;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b_q == 32'd0) begin
          res_hi = a_q;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_lo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
          res_hi = a_neg ? (32'd0 - r_mag) : r_mag;
        end
      end
      default: ;
    endcase
  end

  // A start is only honoured in IDLE with a genuine mult/div opcode.
  logic start_ok;
  always_comb begin
    start_ok = (state_q == S_IDLE) && Start &&
               (MDUOp_E >= OP_MULT) && (MDUOp_E <= OP_DIVU);
`ifdef MDU_DIV0_KEEP_EN
    if (((MDUOp_E == OP_DIV) || (MDUOp_E == OP_DIVU)) && (V2_E == 32'd0))
      start_ok = 1'b0;
`endif
  end

  // Next-state logic: launch, count down, commit; mthi/mtlo only while idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          op_d    = MDUOp_E;
          a_d     = V1_E;
          b_d     = V2_E;
          cnt_d   = ((MDUOp_E == OP_MULT) || (MDUOp_E == OP_MULTU)) ?
                    CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else if (MDUOp_E == OP_MTHI) begin
          hi_d = V1_E;
        end else if (MDUOp_E == OP_MTLO) begin
          lo_d = V1_E;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  // Read-back mux and hazard request.
  always_comb begin
    MDUOut = 32'd0;
    if (MDUOp_E == OP_MFHI)      MDUOut = hi_q;
    else if (MDUOp_E == OP_MFLO) MDUOut = lo_q;
  end

  assign Busy      = busy_q;
  assign Stall_Req = Start | busy_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule
